// File: rtl/game_status_encoder.sv
`default_nettype none
// ============================================================================
// Module   : game_status_encoder
// Brief    : Tile-game session FSM with BCD countdown, BCD score and lives bar,
//            producing registered hex/LED holder values for the display stage.
// Revision : 1.0  initial release
// ============================================================================
module game_status_encoder #(
    parameter int CLK_HZ       = 50_000_000,
    parameter int GAME_SECONDS = 60,
    parameter int LIVES        = 10
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       startGame,
    input  logic       matchHit,
    input  logic       matchMiss,
    input  logic       userquit,
    output logic       ingameOn,
    output logic       gameOver,
    output logic [3:0] hex0hldr,
    output logic [3:0] hex2hldr,
    output logic [3:0] hex3hldr,
    output logic [3:0] hex4hldr,
    output logic [3:0] hex5hldr,
    output logic [9:0] ledrhldr
);

    localparam int             CNT_W      = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;
    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(CLK_HZ - 1);
    localparam logic [3:0]     TIMER_TENS = 4'(GAME_SECONDS / 10);
    localparam logic [3:0]     TIMER_ONES = 4'(GAME_SECONDS % 10);
    localparam logic [3:0]     LIVES_INIT = 4'(LIVES);
    localparam logic [3:0]     BLANK      = 4'hF;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_PLAY = 2'd1;
    localparam logic [1:0] ST_OVER = 2'd2;

    logic [1:0]       state,      state_n;
    logic [CNT_W-1:0] tick_cnt,   tick_cnt_n;
    logic [3:0]       timer_tens, timer_tens_n;
    logic [3:0]       timer_ones, timer_ones_n;
    logic [3:0]       score_tens, score_tens_n;
    logic [3:0]       score_ones, score_ones_n;
    logic [3:0]       lives,      lives_n;
    logic             blink,      blink_n;
    logic             tick;
    logic             do_load;

    logic [3:0] hex0_n, hex2_n, hex3_n, hex4_n, hex5_n;
    logic [9:0] ledr_n;
    logic       ingame_n, over_n;

    assign tick = (tick_cnt == TICK_LAST);

    // State and output registers
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            tick_cnt   <= '0;
            timer_tens <= 4'd0;
            timer_ones <= 4'd0;
            score_tens <= 4'd0;
            score_ones <= 4'd0;
            lives      <= 4'd0;
            blink      <= 1'b0;
            hex0hldr   <= 4'd0;
            hex2hldr   <= BLANK;
            hex3hldr   <= BLANK;
            hex4hldr   <= BLANK;
            hex5hldr   <= BLANK;
            ledrhldr   <= 10'd0;
            ingameOn   <= 1'b0;
            gameOver   <= 1'b0;
        end else begin
            state      <= state_n;
            tick_cnt   <= tick_cnt_n;
            timer_tens <= timer_tens_n;
            timer_ones <= timer_ones_n;
            score_tens <= score_tens_n;
            score_ones <= score_ones_n;
            lives      <= lives_n;
            blink      <= blink_n;
            hex0hldr   <= hex0_n;
            hex2hldr   <= hex2_n;
            hex3hldr   <= hex3_n;
            hex4hldr   <= hex4_n;
            hex5hldr   <= hex5_n;
            ledrhldr   <= ledr_n;
            ingameOn   <= ingame_n;
            gameOver   <= over_n;
        end
    end

    // Next-state and counter updates
    always_comb begin
        state_n      = state;
        tick_cnt_n   = tick_cnt;
        timer_tens_n = timer_tens;
        timer_ones_n = timer_ones;
        score_tens_n = score_tens;
        score_ones_n = score_ones;
        lives_n      = lives;
        blink_n      = blink;
        do_load      = 1'b0;

        if (userquit) begin
            state_n      = ST_IDLE;
            tick_cnt_n   = '0;
            timer_tens_n = 4'd0;
            timer_ones_n = 4'd0;
            score_tens_n = 4'd0;
            score_ones_n = 4'd0;
            lives_n      = 4'd0;
            blink_n      = 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    do_load = startGame;
                end
                ST_PLAY: begin
                    if (tick) begin
                        if (timer_ones == 4'd0) begin
                            timer_ones_n = 4'd9;
                            timer_tens_n = timer_tens - 4'd1;
                        end else begin
                            timer_ones_n = timer_ones - 4'd1;
                        end
                    end
                    if (matchHit && !(score_tens == 4'd9 && score_ones == 4'd9)) begin
                        if (score_ones == 4'd9) begin
                            score_ones_n = 4'd0;
                            score_tens_n = score_tens + 4'd1;
                        end else begin
                            score_ones_n = score_ones + 4'd1;
                        end
                    end
                    if (matchMiss && lives != 4'd0) begin
                        lives_n = lives - 4'd1;
                    end
                    // Leave PLAY on the very update that produces the zero value
                    if ((timer_tens_n == 4'd0 && timer_ones_n == 4'd0) || lives_n == 4'd0) begin
                        state_n    = ST_OVER;
                        tick_cnt_n = '0;
                        blink_n    = 1'b1;
                    end else begin
                        tick_cnt_n = tick ? '0 : tick_cnt + 1'b1;
                    end
                end
                ST_OVER: begin
                    if (startGame) begin
                        do_load = 1'b1;
                    end else begin
                        if (tick) begin
                            blink_n = ~blink;
                        end
                        tick_cnt_n = tick ? '0 : tick_cnt + 1'b1;
                    end
                end
                default: begin
                    state_n = ST_IDLE;
                end
            endcase

            if (do_load) begin
                state_n      = ST_PLAY;
                tick_cnt_n   = '0;
                timer_tens_n = TIMER_TENS;
                timer_ones_n = TIMER_ONES;
                score_tens_n = 4'd0;
                score_ones_n = 4'd0;
                lives_n      = LIVES_INIT;
            end
        end
    end

    // Display values derived from the next state so outputs land one edge after inputs
    always_comb begin
        hex0_n   = 4'd0;
        hex2_n   = BLANK;
        hex3_n   = BLANK;
        hex4_n   = BLANK;
        hex5_n   = BLANK;
        ledr_n   = 10'd0;
        ingame_n = 1'b0;
        over_n   = 1'b0;
        case (state_n)
            ST_PLAY: begin
                hex0_n   = 4'd1;
                hex5_n   = timer_tens_n;
                hex4_n   = timer_ones_n;
                hex3_n   = score_tens_n;
                hex2_n   = score_ones_n;
                for (int i = 0; i < 10; i++) begin
                    ledr_n[i] = (lives_n > 4'(i));
                end
                ingame_n = 1'b1;
            end
            ST_OVER: begin
                hex0_n = 4'd2;
                hex3_n = score_tens_n;
                hex2_n = score_ones_n;
                ledr_n = blink_n ? 10'h3FF : 10'h000;
                over_n = 1'b1;
            end
            default: begin
                hex0_n = 4'd0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_game_status_encoder.sv
`default_nettype none
// Bench for game_status_encoder: integer-level game model compared every cycle,
// plus literal checks on the key scenarios.
module tb_game_status_encoder;

    localparam int CLK_HZ       = 4;
    localparam int GAME_SECONDS = 30;
    localparam int LIVES        = 3;

    logic       CLOCK_50  = 1'b0;
    logic       reset     = 1'b1;
    logic       startGame = 1'b0;
    logic       matchHit  = 1'b0;
    logic       matchMiss = 1'b0;
    logic       userquit  = 1'b0;
    logic       ingameOn, gameOver;
    logic [3:0] hex0hldr, hex2hldr, hex3hldr, hex4hldr, hex5hldr;
    logic [9:0] ledrhldr;

    int n_tests = 0;
    int n_fail  = 0;

    game_status_encoder #(
        .CLK_HZ      (CLK_HZ),
        .GAME_SECONDS(GAME_SECONDS),
        .LIVES       (LIVES)
    ) dut (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .startGame(startGame),
        .matchHit (matchHit),
        .matchMiss(matchMiss),
        .userquit (userquit),
        .ingameOn (ingameOn),
        .gameOver (gameOver),
        .hex0hldr (hex0hldr),
        .hex2hldr (hex2hldr),
        .hex3hldr (hex3hldr),
        .hex4hldr (hex4hldr),
        .hex5hldr (hex5hldr),
        .ledrhldr (ledrhldr)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // Game model in plain integers: mode 0 idle, 1 play, 2 over
    int m_mode = 0, m_timer = 0, m_score = 0, m_lives = 0, m_cnt = 0;
    bit m_blink = 1'b0;
    bit m_tick;

    always @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            m_mode = 0; m_timer = 0; m_score = 0; m_lives = 0; m_cnt = 0; m_blink = 1'b0;
        end else begin
            m_tick = (m_cnt == CLK_HZ - 1);
            if (userquit) begin
                m_mode = 0; m_timer = 0; m_score = 0; m_lives = 0; m_cnt = 0; m_blink = 1'b0;
            end else if (m_mode != 1 && startGame) begin
                m_mode = 1; m_timer = GAME_SECONDS; m_score = 0; m_lives = LIVES; m_cnt = 0;
            end else if (m_mode == 1) begin
                if (m_tick) m_timer = m_timer - 1;
                if (matchHit && m_score < 99) m_score = m_score + 1;
                if (matchMiss && m_lives > 0) m_lives = m_lives - 1;
                if (m_timer == 0 || m_lives == 0) begin
                    m_mode = 2; m_cnt = 0; m_blink = 1'b1;
                end else begin
                    m_cnt = (m_cnt + 1) % CLK_HZ;
                end
            end else if (m_mode == 2) begin
                if (m_tick) m_blink = !m_blink;
                m_cnt = (m_cnt + 1) % CLK_HZ;
            end
        end
    end

    always @(negedge CLOCK_50) begin
        logic [3:0] e5, e4, e3, e2;
        logic [9:0] eledr;
        if (!reset) begin
            e5 = (m_mode == 1) ? 4'(m_timer / 10) : 4'hF;
            e4 = (m_mode == 1) ? 4'(m_timer % 10) : 4'hF;
            e3 = (m_mode == 0) ? 4'hF : 4'(m_score / 10);
            e2 = (m_mode == 0) ? 4'hF : 4'(m_score % 10);
            if (m_mode == 1)      eledr = 10'((1 << m_lives) - 1);
            else if (m_mode == 2) eledr = m_blink ? 10'h3FF : 10'h000;
            else                  eledr = 10'h000;
            check("model_hex", {12'd0, hex0hldr, hex5hldr, hex4hldr, hex3hldr, hex2hldr},
                  {12'd0, 4'(m_mode), e5, e4, e3, e2});
            check("model_ledr", {22'd0, ledrhldr}, {22'd0, eledr});
            check("model_flags", {30'd0, ingameOn, gameOver},
                  {30'd0, (m_mode == 1), (m_mode == 2)});
        end
    end

    task automatic pulse(input bit s, input bit h, input bit m, input bit q);
        startGame = s; matchHit = h; matchMiss = m; userquit = q;
        @(negedge CLOCK_50);
        startGame = 1'b0; matchHit = 1'b0; matchMiss = 1'b0; userquit = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        repeat (3) @(negedge CLOCK_50);
        reset = 1'b0;
        @(negedge CLOCK_50);
        check("reset_hex", {hex0hldr, hex5hldr, hex4hldr, hex3hldr, hex2hldr}, 32'h0FFFF);
        check("reset_ledr", ledrhldr, 0);
        check("reset_flags", {ingameOn, gameOver}, 0);

        pulse(0, 1, 0, 0);
        check("idle_hit_ignored", {hex0hldr, hex3hldr, hex2hldr}, 32'h0FF);

        pulse(1, 0, 0, 0);
        check("start_timer", {hex5hldr, hex4hldr}, 32'h30);
        check("start_score", {hex3hldr, hex2hldr}, 32'h00);
        check("start_ledr", ledrhldr, 32'h007);
        check("start_flags", {hex0hldr, ingameOn, gameOver}, 32'b0110);
        repeat (3) @(negedge CLOCK_50);
        check("before_first_tick", {hex5hldr, hex4hldr}, 32'h30);
        @(negedge CLOCK_50);
        check("first_tick_borrow", {hex5hldr, hex4hldr}, 32'h29);

        matchHit = 1'b1;
        repeat (9) @(negedge CLOCK_50);
        matchHit = 1'b0;
        check("score_09", {hex3hldr, hex2hldr}, 32'h09);
        pulse(0, 1, 0, 0);
        check("score_carry", {hex3hldr, hex2hldr}, 32'h10);

        pulse(0, 1, 1, 0);
        check("hit_miss_score", {hex3hldr, hex2hldr}, 32'h11);
        check("hit_miss_lives", ledrhldr, 32'h003);
        pulse(0, 0, 1, 0);
        check("miss_lives", ledrhldr, 32'h001);
        pulse(0, 0, 1, 0);
        check("over_hex", {hex0hldr, hex5hldr, hex4hldr, hex3hldr, hex2hldr}, 32'h2FF11);
        check("over_flags", {ingameOn, gameOver}, 32'b01);
        check("over_blink_on", ledrhldr, 32'h3FF);
        repeat (3) @(negedge CLOCK_50);
        check("over_blink_hold", ledrhldr, 32'h3FF);
        @(negedge CLOCK_50);
        check("over_blink_off", ledrhldr, 32'h000);
        repeat (4) @(negedge CLOCK_50);
        check("over_blink_back", ledrhldr, 32'h3FF);

        pulse(1, 0, 0, 0);
        check("restart", {hex0hldr, hex5hldr, hex4hldr, hex3hldr, hex2hldr}, 32'h13000);
        check("restart_ledr", ledrhldr, 32'h007);
        matchHit = 1'b1;
        repeat (100) @(negedge CLOCK_50);
        matchHit = 1'b0;
        check("score_saturate", {hex3hldr, hex2hldr}, 32'h99);
        check("timer_after_100", {hex5hldr, hex4hldr}, 32'h05);

        pulse(0, 1, 0, 1);
        check("quit_hex", {hex0hldr, hex5hldr, hex4hldr, hex3hldr, hex2hldr}, 32'h0FFFF);
        check("quit_flags", {ingameOn, gameOver, ledrhldr}, 32'h0);

        pulse(1, 0, 0, 0);
        check("quit_restart_score", {hex3hldr, hex2hldr}, 32'h00);
        repeat (119) @(negedge CLOCK_50);
        check("timer_last_second", {hex5hldr, hex4hldr}, 32'h01);
        pulse(0, 1, 0, 0);
        check("expiry_flags", {hex0hldr, ingameOn, gameOver}, 32'b1001);
        check("expiry_hit_counted", {hex3hldr, hex2hldr}, 32'h01);

        repeat (1500) begin
            startGame = ($urandom_range(0, 99) < 3);
            matchHit  = ($urandom_range(0, 99) < 30);
            matchMiss = ($urandom_range(0, 99) < 5);
            userquit  = ($urandom_range(0, 199) < 1);
            @(negedge CLOCK_50);
        end
        startGame = 1'b0; matchHit = 1'b0; matchMiss = 1'b0; userquit = 1'b0;

        pulse(1, 0, 0, 0);
        repeat (5) @(negedge CLOCK_50);
        reset = 1'b1;
        #1;
        check("async_reset_hex", {hex0hldr, hex5hldr, hex4hldr, hex3hldr, hex2hldr}, 32'h0FFFF);
        check("async_reset_rest", {ingameOn, gameOver, ledrhldr}, 32'h0);
        @(negedge CLOCK_50);
        reset = 1'b0;
        repeat (3) @(negedge CLOCK_50);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
